mac_operand_driver: RTL and testbench

MAC_OPERAND_DRIVER -- requirements
Module: mac_operand_driver

---
 rtl/mac_operand_driver.sv | 179 +++++++++++++++++
 tb/tb_mac_operand_driver.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mac_operand_driver.sv
// mac_operand_driver
//   Buffers signed operand pairs in a small FIFO and feeds them one at a time
//   to an external multiply-accumulate unit, then reports the dot product of
//   a job as the difference between the MAC accumulator now and its value at
//   the end of the previous successful job.
//
// Ports
//   clk, reset            sole clock; synchronous active-high reset
//   start, len            launch a job of len pairs (only honoured when idle)
//   in_valid, in_a, in_b  operand pair offered to the FIFO
//   in_ready              FIFO has room
//   mac_valid             one-cycle request to the MAC
//   mac_a, mac_b          operands to the MAC, held until the MAC answers
//   mac_done, mac_y       MAC completion pulse and accumulator value
//   mac_overflow          MAC overflow flag, sampled with mac_done
//   res_valid, res_ready  result handshake
//   res_data              job dot product (32-bit wrap)
//   res_ovf, res_err      overflow seen during job / job aborted by timeout
//   busy                  controller not idle
module mac_operand_driver #(
    parameter int DEPTH   = 4,
    parameter int CNT_W   = 8,
    parameter int TIMEOUT = 15
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic [CNT_W-1:0]    len,
    input  logic                in_valid,
    input  logic signed [7:0]   in_a,
    input  logic signed [7:0]   in_b,
    output logic                in_ready,
    output logic                mac_valid,
    output logic signed [7:0]   mac_a,
    output logic signed [7:0]   mac_b,
    input  logic                mac_done,
    input  logic signed [31:0]  mac_y,
    input  logic                mac_overflow,
    output logic                res_valid,
    output logic signed [31:0]  res_data,
    output logic                res_ovf,
    output logic                res_err,
    input  logic                res_ready,
    output logic                busy
);

    localparam int AW = $clog2(DEPTH);
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] FETCH  = 3'd1;
    localparam logic [2:0] ISSUE  = 3'd2;
    localparam logic [2:0] WAIT   = 3'd3;
    localparam logic [2:0] RESULT = 3'd4;

    logic [2:0]          state;
    logic [15:0]         mem [DEPTH];
    // One extra pointer bit distinguishes full from empty.
    logic [AW:0]         wr_ptr;
    logic [AW:0]         rd_ptr;
    logic                full;
    logic                empty;
    logic                push;
    logic                pop;
    logic [CNT_W-1:0]    cnt;
    logic                ovf;
    logic [TW-1:0]       tmo;
    logic signed [31:0]  base;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

    // Acceptance depends only on registered occupancy, so a full FIFO refuses
    // a push even while it is being popped, and a fresh entry cannot be
    // popped in the cycle it arrives.
    assign in_ready  = !full;
    assign push      = in_valid && !full;
    assign pop       = (state == FETCH) && !empty;

    assign mac_valid = (state == ISSUE);
    assign res_valid = (state == RESULT);
    assign busy      = (state != IDLE);

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr[AW-1:0]] <= {in_a, in_b};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            cnt      <= '0;
            ovf      <= 1'b0;
            tmo      <= '0;
            base     <= '0;
            mac_a    <= '0;
            mac_b    <= '0;
            res_data <= '0;
            res_ovf  <= 1'b0;
            res_err  <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + (AW + 1)'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + (AW + 1)'(1);
            end

            case (state)
                IDLE: begin
                    if (start) begin
                        if (len != '0) begin
                            cnt   <= len;
                            ovf   <= 1'b0;
                            state <= FETCH;
                        end else begin
                            res_data <= '0;
                            res_ovf  <= 1'b0;
                            res_err  <= 1'b0;
                            state    <= RESULT;
                        end
                    end
                end

                FETCH: begin
                    if (!empty) begin
                        {mac_a, mac_b} <= mem[rd_ptr[AW-1:0]];
                        state          <= ISSUE;
                    end
                end

                ISSUE: begin
                    tmo   <= '0;
                    state <= WAIT;
                end

                WAIT: begin
                    if (mac_done) begin
                        ovf <= ovf | mac_overflow;
                        cnt <= cnt - CNT_W'(1);
                        if (cnt == CNT_W'(1)) begin
                            // The MAC keeps accumulating across jobs; the job
                            // result is the growth since the last good job.
                            res_data <= mac_y - base;
                            base     <= mac_y;
                            res_ovf  <= ovf | mac_overflow;
                            res_err  <= 1'b0;
                            state    <= RESULT;
                        end else begin
                            state <= FETCH;
                        end
                    end else if (tmo == TMO_LAST) begin
                        // Abort leaves base alone so the next job still
                        // measures from the last good accumulator value.
                        res_data <= '0;
                        res_ovf  <= ovf;
                        res_err  <= 1'b1;
                        state    <= RESULT;
                    end else begin
                        tmo <= tmo + TW'(1);
                    end
                end

                RESULT: begin
                    if (res_ready) begin
                        state <= IDLE;
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mac_operand_driver.sv
// tb_mac_operand_driver
//   Drives mac_operand_driver with directed and random jobs. A behavioural MAC
//   with programmable latency answers the requests; the expected job result is
//   the plain dot product of the pairs the job should consume.
module tb_mac_operand_driver;

    localparam int DEPTH   = 4;
    localparam int CNT_W   = 8;
    localparam int TIMEOUT = 15;

    logic               clk = 1'b0;
    logic               reset;
    logic               start;
    logic [CNT_W-1:0]   len;
    logic               in_valid;
    logic signed [7:0]  in_a;
    logic signed [7:0]  in_b;
    logic               in_ready;
    logic               mac_valid;
    logic signed [7:0]  mac_a;
    logic signed [7:0]  mac_b;
    logic               mac_done;
    logic signed [31:0] mac_y;
    logic               mac_overflow;
    logic               res_valid;
    logic signed [31:0] res_data;
    logic               res_ovf;
    logic               res_err;
    logic               res_ready;
    logic               busy;

    int n_chk  = 0;
    int n_fail = 0;
    int cyc    = 0;

    // Pairs the bench expects to be sitting in the FIFO, oldest first.
    logic signed [7:0] qa[$];
    logic signed [7:0] qb[$];

    int mac_lat  = 3;
    bit mac_mute = 1'b0;

    mac_operand_driver #(.DEPTH(DEPTH), .CNT_W(CNT_W), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .reset(reset), .start(start), .len(len),
        .in_valid(in_valid), .in_a(in_a), .in_b(in_b), .in_ready(in_ready),
        .mac_valid(mac_valid), .mac_a(mac_a), .mac_b(mac_b),
        .mac_done(mac_done), .mac_y(mac_y), .mac_overflow(mac_overflow),
        .res_valid(res_valid), .res_data(res_data), .res_ovf(res_ovf),
        .res_err(res_err), .res_ready(res_ready), .busy(busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural MAC: y accumulates a*b, answered mac_lat cycles after the
    // request; overflow is flagged whenever operand A is -128.
    int                acc = 0;
    bit                pend = 1'b0;
    int                lat_left = 0;
    logic signed [7:0] cap_a = '0;
    logic signed [7:0] cap_b = '0;

    always @(posedge clk) begin
        mac_done <= 1'b0;
        if (reset) begin
            acc          = 0;
            pend         = 1'b0;
            mac_y        <= '0;
            mac_overflow <= 1'b0;
        end else if (mac_valid && !mac_mute) begin
            cap_a = mac_a;
            cap_b = mac_b;
            if (mac_lat <= 1) begin
                acc          = acc + int'(cap_a) * int'(cap_b);
                mac_y        <= acc;
                mac_overflow <= (cap_a == -8'sd128);
                mac_done     <= 1'b1;
            end else begin
                pend     = 1'b1;
                lat_left = mac_lat - 1;
            end
        end else if (pend) begin
            if (lat_left == 1) begin
                acc          = acc + int'(cap_a) * int'(cap_b);
                mac_y        <= acc;
                mac_overflow <= (cap_a == -8'sd128);
                mac_done     <= 1'b1;
                pend         = 1'b0;
            end else begin
                lat_left = lat_left - 1;
            end
        end
    end

    task automatic chk(input string tag, input longint got, input longint exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        qa.delete();
        qb.delete();
    endtask

    task automatic chk_idle_outputs(input string tag);
        @(negedge clk);
        chk({tag, "_in_ready"}, in_ready, 1);
        chk({tag, "_mac_valid"}, mac_valid, 0);
        chk({tag, "_mac_a"}, mac_a, 0);
        chk({tag, "_mac_b"}, mac_b, 0);
        chk({tag, "_res_valid"}, res_valid, 0);
        chk({tag, "_res_data"}, res_data, 0);
        chk({tag, "_res_ovf"}, res_ovf, 0);
        chk({tag, "_res_err"}, res_err, 0);
        chk({tag, "_busy"}, busy, 0);
    endtask

    task automatic push_pair(input logic signed [7:0] a, input logic signed [7:0] b);
        bit room;
        @(negedge clk);
        room = (qa.size() < DEPTH);
        chk("in_ready", in_ready, room);
        in_valid = 1'b1;
        in_a     = a;
        in_b     = b;
        @(posedge clk);
        #1 in_valid = 1'b0;
        if (room) begin
            qa.push_back(a);
            qb.push_back(b);
        end
    endtask

    // Runs one job of n pairs and checks issue order, result and handshake.
    // period: cycles between the last two issues; lat: issue-to-result cycles.
    task automatic run_job(input int n, input bit exp_err, input int hold,
                           output int period, output int lat);
        int                exp_sum = 0;
        bit                exp_ovf = 1'b0;
        int                issued  = 0;
        int                t_iss   = -1;
        bit                got     = 1'b0;
        logic signed [7:0] la = '0;
        logic signed [7:0] lb = '0;
        period = 0;
        lat    = 0;
        if (!exp_err) begin
            for (int i = 0; i < n && i < qa.size(); i++) begin
                exp_sum += int'(qa[i]) * int'(qb[i]);
                exp_ovf |= (qa[i] == -8'sd128);
            end
        end
        @(posedge clk);
        #1 start = 1'b1;
        len = CNT_W'(n);
        @(posedge clk);
        #1 start = 1'b0;
        for (int c = 0; c < n * 20 + 40 && !got; c++) begin
            @(negedge clk);
            if (mac_valid) begin
                if (qa.size() == 0) begin
                    chk("issue_from_empty", 1, 0);
                end else begin
                    chk("issue_a", mac_a, qa[0]);
                    chk("issue_b", mac_b, qb[0]);
                    void'(qa.pop_front());
                    void'(qb.pop_front());
                end
                la = mac_a;
                lb = mac_b;
                issued++;
                if (t_iss >= 0) period = cyc - t_iss;
                t_iss = cyc;
            end
            if (mac_done) begin
                chk("hold_a", mac_a, la);
                chk("hold_b", mac_b, lb);
            end
            if (res_valid) begin
                got = 1'b1;
                if (t_iss >= 0) lat = cyc - t_iss;
            end
        end
        chk("res_seen", got, 1);
        chk("res_data", res_data, exp_sum);
        chk("res_ovf", res_ovf, exp_ovf);
        chk("res_err", res_err, exp_err);
        chk("issued", issued, exp_err ? ((n > 0) ? 1 : 0) : n);
        for (int h = 0; h < hold; h++) begin
            start = (h == 1);
            len   = 8'd1;
            @(negedge clk);
            chk("hold_valid", res_valid, 1);
            chk("hold_data", res_data, exp_sum);
            chk("hold_no_issue", mac_valid, 0);
        end
        start     = 1'b0;
        res_ready = 1'b1;
        @(posedge clk);
        #1 res_ready = 1'b0;
        @(negedge clk);
        chk("after_ack_busy", busy, 0);
        chk("after_ack_valid", res_valid, 0);
    endtask

    initial begin
        int per;
        int lat;
        int n;
        bit seen;
        reset     = 1'b1;
        start     = 1'b0;
        len       = '0;
        in_valid  = 1'b0;
        in_a      = '0;
        in_b      = '0;
        res_ready = 1'b0;

        do_reset();
        chk_idle_outputs("reset");

        // Basic three-pair job with a 3-cycle MAC.
        mac_lat = 3;
        push_pair(8'sd3, 8'sd4);
        push_pair(-8'sd2, 8'sd5);
        push_pair(8'sd7, 8'sd7);
        run_job(3, 1'b0, 2, per, lat);
        chk("issue_period", per, 5);

        // Second job continues the MAC accumulation.
        push_pair(8'sd1, 8'sd1);
        push_pair(8'sd2, 8'sd2);
        run_job(2, 1'b0, 0, per, lat);

        // Empty job: result appears in the cycle right after start.
        run_job(0, 1'b0, 0, per, lat);

        // Fill the FIFO; the fifth offer must be refused.
        push_pair(8'sd10, -8'sd1);
        push_pair(8'sd11, -8'sd2);
        push_pair(8'sd12, -8'sd3);
        push_pair(8'sd13, -8'sd4);
        push_pair(8'sd99, 8'sd99);
        chk("fifo_level", qa.size(), DEPTH);
        run_job(4, 1'b0, 0, per, lat);

        // MAC never answers: timeout after the full WAIT budget.
        mac_mute = 1'b1;
        push_pair(8'sd5, 8'sd6);
        push_pair(-8'sd3, 8'sd9);
        push_pair(8'sd4, -8'sd8);
        run_job(3, 1'b1, 0, per, lat);
        chk("tmo_latency", lat, TIMEOUT + 1);
        chk("tmo_leftover", qa.size(), 2);
        mac_mute = 1'b0;
        // Leftover pairs still queued; result proves base was untouched.
        run_job(2, 1'b0, 0, per, lat);

        // Result held while the consumer stalls; start is ignored meanwhile.
        push_pair(-8'sd128, 8'sd2);
        run_job(1, 1'b0, 10, per, lat);

        // Reset in the middle of WAIT abandons the job.
        mac_lat = 5;
        push_pair(8'sd20, 8'sd20);
        push_pair(8'sd21, 8'sd21);
        @(posedge clk);
        #1 start = 1'b1;
        len = 8'd2;
        @(posedge clk);
        #1 start = 1'b0;
        seen = 1'b0;
        for (int c = 0; c < 20 && !seen; c++) begin
            @(negedge clk);
            seen = mac_valid;
        end
        chk("midwait_issue_seen", seen, 1);
        @(negedge clk);
        do_reset();
        chk_idle_outputs("midreset");
        seen = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (res_valid) seen = 1'b1;
        end
        chk("midreset_no_result", seen, 0);
        mac_lat = 3;
        push_pair(-8'sd7, 8'sd6);
        run_job(1, 1'b0, 0, per, lat);

        // Random jobs.
        for (int it = 0; it < 25; it++) begin
            mac_lat = int'($urandom_range(5, 1));
            n = ($urandom_range(7, 0) == 0) ? 0 : int'($urandom_range(DEPTH, 1));
            for (int k = 0; k < n; k++) begin
                logic signed [7:0] ra;
                logic signed [7:0] rb;
                ra = ($urandom_range(7, 0) == 0) ? -8'sd128 : 8'($urandom);
                rb = 8'($urandom);
                push_pair(ra, rb);
            end
            run_job(n, 1'b0, int'($urandom_range(3, 0)), per, lat);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
